bcd_dn_timer: RTL and testbench

//   Multi-digit loadable BCD countdown timer: the down-counting, borrow-propagating companion to the

---
 rtl/bcd_tmr_pkg.sv | 18 +
 rtl/bcd_dn_digit.sv | 26 ++
 rtl/bcd_dn_timer.sv | 122 ++++++++++++
 tb/tb_bcd_dn_timer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_tmr_pkg.sv
// Shared definitions for the BCD countdown timer: FSM encoding, the digit limit
// and the load-time nibble clamp.
package bcd_tmr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage

// File: rtl/bcd_dn_digit.sv
// One BCD digit of the countdown chain: loads, or steps down by one when a borrow
// arrives, wrapping 0 -> 9 and passing the borrow upward.
module bcd_dn_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       ld_n,
    input  logic [3:0] d,
    input  logic       bin,
    output logic [3:0] q,
    output logic       bout
);
    import bcd_tmr_pkg::*;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= 4'd0;
        end else if (!ld_n) begin
            q <= d;
        end else if (bin) begin
            q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
        end
    end

    assign bout = bin & (q == 4'd0);

endmodule

// File: rtl/bcd_dn_timer.sv
// Loadable multi-digit BCD countdown timer with run/pause control, optional
// auto-reload on expiry and a one-cycle done pulse.
module bcd_dn_timer #(
    parameter int DIGITS      = 2,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [4*DIGITS-1:0] data,
    input  logic                start,
    input  logic                stop,
    output logic [4*DIGITS-1:0] dout,
    output logic                zero,
    output logic                busy,
    output logic                done
);
    import bcd_tmr_pkg::*;

    localparam logic [4*DIGITS-1:0] COUNT_ONE = (4*DIGITS)'(1);

    state_t              state;
    state_t              state_nxt;
    logic [4*DIGITS-1:0] reload;
    logic [4*DIGITS-1:0] data_clamped;
    logic [4*DIGITS-1:0] ld_val;
    logic [DIGITS:0]     borrow;
    logic                reload_now;
    logic                ld_n;
    logic                expire;

    always_comb begin
        data_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            data_clamped[4*i +: 4] = bcd_clamp(data[4*i +: 4]);
        end
    end

    // DONE reuses the digit load path to restart from the reload value.
    assign reload_now = AUTO_RELOAD && (state == ST_DONE) && (reload != '0);
    assign ld_n       = load & ~reload_now;
    assign ld_val     = load ? reload : data_clamped;

    // Holding off at zero keeps the chain from ever wrapping below 00.
    assign borrow[0] = (state == ST_RUN) & en & ~stop & ~zero;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_dn_digit u_digit (
            .clk  (clk),
            .rst  (rst),
            .ld_n (ld_n),
            .d    (ld_val[4*g +: 4]),
            .bin  (borrow[g]),
            .q    (dout[4*g +: 4]),
            .bout (borrow[g+1])
        );
    end

    // A borrow out of the top digit would mean 00 was decremented; treat it as expiry.
    assign expire = en & ((dout == COUNT_ONE) | borrow[DIGITS]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            reload <= '0;
        end else if (!load) begin
            reload <= data_clamped;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!load) begin
            state_nxt = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_nxt = zero ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_nxt = ST_PAUSE;
                    end else if (expire) begin
                        state_nxt = ST_DONE;
                    end
                end
                ST_PAUSE: begin
                    if (start && !stop) begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_nxt = reload_now ? ST_RUN : ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            ST_RUN, ST_PAUSE: busy = 1'b1;
            ST_DONE:          done = 1'b1;
            default: ;
        endcase
    end

    assign zero = (dout == '0);

endmodule

// File: tb/tb_bcd_dn_timer.sv
// Bench for bcd_dn_timer: vector table plus hand sequences, results checked
// through an expected-value queue one cycle after each stimulus.
module tb_bcd_dn_timer;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct packed {
        logic [7:0] dout;
        logic       zero;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct packed {
        logic       rst;
        logic       load;
        logic [7:0] data;
        logic       start;
        logic       stop;
        logic       en;
        exp_t       e;
    } vec_t;

    typedef struct packed {
        exp_t e;
        logic sel;
    } sb_t;

    logic       clk;
    logic       rst, en, load, start, stop;
    logic [7:0] data;
    logic [7:0] dout0, dout1;
    logic       zero0, busy0, done0;
    logic       zero1, busy1, done1;

    int passed = 0;
    int total  = 0;

    vec_t vecs[$];
    sb_t  sb[$];

    bcd_dn_timer #(.DIGITS(2), .AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
        .start(start), .stop(stop), .dout(dout0), .zero(zero0), .busy(busy0), .done(done0)
    );

    bcd_dn_timer #(.DIGITS(2), .AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .data(data),
        .start(start), .stop(stop), .dout(dout1), .zero(zero1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk_e(input logic [7:0] q, input logic z, b, d);
        exp_t x;
        x.dout = q;
        x.zero = z;
        x.busy = b;
        x.done = d;
        return x;
    endfunction

    function automatic vec_t mk(input logic r, ld, input logic [7:0] d, input logic s, sp, e,
                                input logic [7:0] q, input logic z, b, dn);
        vec_t v;
        v.rst   = r;
        v.load  = ld;
        v.data  = d;
        v.start = s;
        v.stop  = sp;
        v.en    = e;
        v.e     = mk_e(q, z, b, dn);
        return v;
    endfunction

    function automatic logic [7:0] bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        else passed++;
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input logic r, ld, input logic [7:0] d, input logic s, sp, e,
                        input exp_t ex, input logic sel, input string nm);
        sb_t  cur;
        exp_t act;
        rst   = r;
        load  = ld;
        data  = d;
        start = s;
        stop  = sp;
        en    = e;
        cur.e   = ex;
        cur.sel = sel;
        sb.push_back(cur);
        @(posedge clk);
        #1;
        cur = sb.pop_front();
        act = cur.sel ? {dout1, zero1, busy1, done1} : {dout0, zero0, busy0, done0};
        chk({nm, ".dout"}, act.dout, cur.e.dout);
        chk({nm, ".zero"}, 8'(act.zero), 8'(cur.e.zero));
        chk({nm, ".busy"}, 8'(act.busy), 8'(cur.e.busy));
        chk({nm, ".done"}, 8'(act.done), 8'(cur.e.done));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; load = 1'b1; data = 8'h00; start = 1'b0; stop = 1'b0; en = 1'b0;

        // Countdown from 12 to 00 with done pulse, then return to idle
        vecs.push_back(mk(H, L, 8'h12, L, L, L, 8'h12, L, L, L));
        vecs.push_back(mk(H, H, 8'h00, H, L, H, 8'h12, L, H, L));
        for (int n = 11; n >= 1; n--) vecs.push_back(mk(H, H, 8'h00, H, L, H, bcd(n), L, H, L));
        vecs.push_back(mk(H, H, 8'h00, H, L, H, 8'h00, H, L, H));
        vecs.push_back(mk(H, H, 8'h00, L, L, H, 8'h00, H, L, L));
        vecs.push_back(mk(H, H, 8'h00, L, L, H, 8'h00, H, L, L));
        // Borrow 10 -> 09, clamped load 3C -> 39
        vecs.push_back(mk(H, L, 8'h10, L, L, L, 8'h10, L, L, L));
        vecs.push_back(mk(H, H, 8'h00, H, L, L, 8'h10, L, H, L));
        vecs.push_back(mk(H, H, 8'h00, L, L, H, 8'h09, L, H, L));
        vecs.push_back(mk(H, H, 8'h00, L, L, L, 8'h09, L, H, L));
        vecs.push_back(mk(H, L, 8'h3C, L, L, H, 8'h39, L, L, L));
        // Pause at 05 with en held, resume to 04
        vecs.push_back(mk(H, L, 8'h08, L, L, L, 8'h08, L, L, L));
        vecs.push_back(mk(H, H, 8'h00, H, L, L, 8'h08, L, H, L));
        vecs.push_back(mk(H, H, 8'h00, L, L, H, 8'h07, L, H, L));
        vecs.push_back(mk(H, H, 8'h00, L, L, H, 8'h06, L, H, L));
        vecs.push_back(mk(H, H, 8'h00, L, L, H, 8'h05, L, H, L));
        vecs.push_back(mk(H, H, 8'h00, L, H, H, 8'h05, L, H, L));
        vecs.push_back(mk(H, H, 8'h00, L, H, H, 8'h05, L, H, L));
        vecs.push_back(mk(H, H, 8'h00, H, L, L, 8'h05, L, H, L));
        vecs.push_back(mk(H, H, 8'h00, L, L, H, 8'h04, L, H, L));

        // Reset held two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            step(L, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 mk_e(8'h00, H, L, L), L, "reset");
            chk("reset.dout1", dout1, 8'h00);
            chk("reset.busy1", 8'(busy1), 8'h00);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].load, vecs[i].data, vecs[i].start, vecs[i].stop,
                 vecs[i].en, vecs[i].e, L, $sformatf("vec%0d", i));
        end

        // Load overrides a running count
        step(H, H, 8'h00, L, L, H, mk_e(8'h03, L, H, L), L, "run03");
        step(H, L, 8'h07, H, L, H, mk_e(8'h07, L, L, L), L, "load_mid");
        step(H, H, 8'h00, L, L, H, mk_e(8'h07, L, L, L), L, "idle_hold");
        // Reset during RUN: no done pulse
        step(H, H, 8'h00, H, L, L, mk_e(8'h07, L, H, L), L, "start07");
        step(H, H, 8'h00, L, L, H, mk_e(8'h06, L, H, L), L, "run06");
        step(L, H, 8'h00, L, L, H, mk_e(8'h00, H, L, L), L, "rst_mid");
        step(H, H, 8'h00, L, L, H, mk_e(8'h00, H, L, L), L, "post_rst");
        // Start with a zero count gives a single done pulse
        step(H, H, 8'h00, H, L, L, mk_e(8'h00, H, L, H), L, "start_zero");
        step(H, H, 8'h00, L, L, L, mk_e(8'h00, H, L, L), L, "zero_idle");
        step(H, H, 8'h00, L, L, L, mk_e(8'h00, H, L, L), L, "zero_idle2");
        // Both nibbles clamped, then one tick
        step(H, L, 8'hFA, L, L, L, mk_e(8'h99, L, L, L), L, "clamp_fa");
        step(H, H, 8'h00, H, L, L, mk_e(8'h99, L, H, L), L, "start99");
        step(H, H, 8'h00, L, L, H, mk_e(8'h98, L, H, L), L, "tick98");

        // Auto-reload instance: 02 -> 01 -> 00/done -> 02 ... until stop
        step(H, L, 8'h02, L, L, L, mk_e(8'h02, L, L, L), H, "ar_load");
        step(H, H, 8'h00, H, L, H, mk_e(8'h02, L, H, L), H, "ar_start");
        step(H, H, 8'h00, L, L, H, mk_e(8'h01, L, H, L), H, "ar_01a");
        step(H, H, 8'h00, L, L, H, mk_e(8'h00, H, L, H), H, "ar_done_a");
        step(H, H, 8'h00, L, L, H, mk_e(8'h02, L, H, L), H, "ar_reload_a");
        step(H, H, 8'h00, L, L, H, mk_e(8'h01, L, H, L), H, "ar_01b");
        step(H, H, 8'h00, L, L, H, mk_e(8'h00, H, L, H), H, "ar_done_b");
        step(H, H, 8'h00, L, L, H, mk_e(8'h02, L, H, L), H, "ar_reload_b");
        step(H, H, 8'h00, L, H, H, mk_e(8'h02, L, H, L), H, "ar_stop");
        step(H, H, 8'h00, L, H, H, mk_e(8'h02, L, H, L), H, "ar_stop2");
        step(H, H, 8'h00, L, L, H, mk_e(8'h02, L, H, L), H, "ar_paused");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
